pong_game_sequencer: RTL and testbench

//  Top-level game state machine for Ball-and-Paddle. Sequences serve / play / pause / game-over.

---
 rtl/pong_game_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pong_game_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer
// Top-level game state machine for Ball-and-Paddle: sequences serve, play,
// pause and game-over, keeps both scores, steers the ball engine and
// shrinks the bats as the match progresses.
//
// Ports
//   clk          system clock
//   rst          synchronous active-low reset
//   start_n      start/pause button, active-low, asynchronous to clk
//   frame_tick   one-cycle pulse per video frame
//   miss_left    ball passed P1 (left) edge, one-cycle pulse
//   miss_right   ball passed P2 (right) edge, one-cycle pulse
//   ball_run     ball engine advances position
//   ball_center  ball engine holds ball at screen centre
//   serve_dir    0 = serve toward P1, 1 = toward P2
//   bat_size     1 = large bat, 0 = small bat
//   score_p1     P1 score
//   score_p2     P2 score
//   game_over    high while in GAMEOVER
//   winner       0 = P1, 1 = P2; valid while game_over is high
//   state_dbg    encoded state: IDLE=0 SERVE=1 PLAY=2 PAUSE=3 GAMEOVER=4
module pong_game_sequencer #(
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SHRINK_SCORE = 5,
  parameter int unsigned SERVE_DELAY  = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_n,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_dir,
  output logic               bat_size,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    PAUSE    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SHRINK = SCORE_W'(SHRINK_SCORE);
  localparam logic [7:0]         DELAY  = 8'(SERVE_DELAY);

  state_t               state, state_n;
  logic [SCORE_W-1:0]   p1_n, p2_n;
  logic                 serve_dir_n, winner_n, bat_size_n;
  logic [7:0]           cnt, cnt_n;
  logic                 sync1, sync2, hist;
  logic                 press;

  // Falling edge of the synchronised button; a held button yields one press.
  assign press = hist & ~sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= start_n;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_comb begin
    state_n     = state;
    p1_n        = score_p1;
    p2_n        = score_p2;
    serve_dir_n = serve_dir;
    winner_n    = winner;
    cnt_n       = cnt;
    case (state)
      IDLE, GAMEOVER: begin
        if (press) begin
          state_n     = SERVE;
          p1_n        = '0;
          p2_n        = '0;
          serve_dir_n = 1'b0;
          winner_n    = 1'b0;
          cnt_n       = DELAY;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) state_n = PLAY;
        end
      end
      PLAY: begin
        // Press wins over a same-cycle miss; simultaneous misses cancel.
        if (press) begin
          state_n = PAUSE;
        end else if (miss_left && !miss_right) begin
          p2_n        = score_p2 + 1'b1;
          serve_dir_n = 1'b0;
          if (p2_n == WIN) begin
            state_n  = GAMEOVER;
            winner_n = 1'b1;
          end else begin
            state_n = SERVE;
            cnt_n   = DELAY;
          end
        end else if (miss_right && !miss_left) begin
          p1_n        = score_p1 + 1'b1;
          serve_dir_n = 1'b1;
          if (p1_n == WIN) begin
            state_n  = GAMEOVER;
            winner_n = 1'b0;
          end else begin
            state_n = SERVE;
            cnt_n   = DELAY;
          end
        end
      end
      PAUSE: begin
        if (press) state_n = PLAY;
      end
      default: state_n = IDLE;
    endcase
    // Derived from next-state scores so it changes on the scoring edge.
    bat_size_n = !((p1_n >= SHRINK) || (p2_n >= SHRINK));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      score_p1  <= '0;
      score_p2  <= '0;
      serve_dir <= 1'b0;
      winner    <= 1'b0;
      bat_size  <= 1'b1;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      score_p1  <= p1_n;
      score_p2  <= p2_n;
      serve_dir <= serve_dir_n;
      winner    <= winner_n;
      bat_size  <= bat_size_n;
      cnt       <= cnt_n;
    end
  end

  assign ball_run    = (state == PLAY);
  assign ball_center = (state == IDLE) || (state == SERVE) || (state == GAMEOVER);
  assign game_over   = (state == GAMEOVER);
  assign state_dbg   = state;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer with SERVE_DELAY=3, WIN_SCORE=3,
// SHRINK_SCORE=2. Inputs change 1 time unit after a rising edge; outputs
// are checked at the same point, away from the active edge.
module tb_pong_game_sequencer;

  logic       clk = 1'b0;
  logic       rst, start_n, frame_tick, miss_left, miss_right;
  logic       ball_run, ball_center, serve_dir, bat_size, game_over, winner;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state_dbg;

  int unsigned tests = 0;
  int unsigned fails = 0;

  pong_game_sequencer #(
    .SCORE_W     (4),
    .WIN_SCORE   (3),
    .SHRINK_SCORE(2),
    .SERVE_DELAY (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_n    (start_n),
    .frame_tick (frame_tick),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_run   (ball_run),
    .ball_center(ball_center),
    .serve_dir  (serve_dir),
    .bat_size   (bat_size),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over),
    .winner     (winner),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Button low for one sample; the state acts on the third edge.
  task automatic press_btn();
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    step();
    step();
  endtask

  task automatic serve_ticks();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    rst = 1'b0; start_n = 1'b1; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;

    // 1: reset
    step(); step();
    check("rst_state", state_dbg, 0);
    check("rst_p1", score_p1, 0);
    check("rst_p2", score_p2, 0);
    check("rst_center", ball_center, 1);
    check("rst_run", ball_run, 0);
    check("rst_bat", bat_size, 1);
    check("rst_go", game_over, 0);
    rst = 1'b1;

    // 2: press to SERVE, then 3 ticks to PLAY
    start_n = 1'b0; step(); start_n = 1'b1; step();
    check("press_lat_idle", state_dbg, 0);
    step();
    check("serve_state", state_dbg, 1);
    check("serve_center", ball_center, 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("serve_2ticks", state_dbg, 1);
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("play_state", state_dbg, 2);
    check("play_run", ball_run, 1);
    check("play_center", ball_center, 0);

    // 3: P1 scores, then simultaneous misses
    miss_right = 1'b1; step(); miss_right = 1'b0;
    check("p1_score", score_p1, 1);
    check("p1_dir", serve_dir, 1);
    check("p1_serve", state_dbg, 1);
    serve_ticks();
    check("play2", state_dbg, 2);
    miss_left = 1'b1; miss_right = 1'b1; step(); miss_left = 1'b0; miss_right = 1'b0;
    check("both_state", state_dbg, 2);
    check("both_p1", score_p1, 1);
    check("both_p2", score_p2, 0);

    // 4: P2 to 2 (bat shrinks), then P2 wins
    miss_left = 1'b1; step(); miss_left = 1'b0;
    check("p2_1", score_p2, 1);
    check("p2_1_dir", serve_dir, 0);
    check("p2_1_bat", bat_size, 1);
    serve_ticks();
    miss_left = 1'b1; step(); miss_left = 1'b0;
    check("p2_2", score_p2, 2);
    check("p2_2_bat", bat_size, 0);
    serve_ticks();
    miss_left = 1'b1; step(); miss_left = 1'b0;
    check("win_state", state_dbg, 4);
    check("win_go", game_over, 1);
    check("win_who", winner, 1);
    check("win_p2", score_p2, 3);
    check("win_bat", bat_size, 0);
    check("win_center", ball_center, 1);
    press_btn();
    check("restart_state", state_dbg, 1);
    check("restart_p1", score_p1, 0);
    check("restart_p2", score_p2, 0);
    check("restart_bat", bat_size, 1);
    check("restart_winner", winner, 0);
    check("restart_go", game_over, 0);

    // 5: pause handling
    serve_ticks();
    check("play3", state_dbg, 2);
    press_btn();
    check("pause_state", state_dbg, 3);
    check("pause_run", ball_run, 0);
    check("pause_center", ball_center, 0);
    miss_left = 1'b1; step(); miss_left = 1'b0;
    check("pause_miss_p2", score_p2, 0);
    check("pause_miss_state", state_dbg, 3);
    press_btn();
    check("resume", state_dbg, 2);
    start_n = 1'b0; step(); start_n = 1'b1; step();
    miss_left = 1'b1; step(); miss_left = 1'b0;
    check("press_miss_state", state_dbg, 3);
    check("press_miss_p2", score_p2, 0);

    // 6: reset mid-PLAY with score_p1=2
    press_btn();
    miss_right = 1'b1; step(); miss_right = 1'b0;
    serve_ticks();
    miss_right = 1'b1; step(); miss_right = 1'b0;
    serve_ticks();
    check("pre_rst_state", state_dbg, 2);
    check("pre_rst_p1", score_p1, 2);
    check("pre_rst_dir", serve_dir, 1);
    rst = 1'b0; step();
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_p1", score_p1, 0);
    check("mid_rst_bat", bat_size, 1);
    check("mid_rst_dir", serve_dir, 0);
    check("mid_rst_center", ball_center, 1);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
